// File: rtl/gf_sbox_engine.sv
// GF(2^m) multiplicative-inverse engine with optional AES forward/inverse S-box affine stages.
// Inverse is a^(2^m-2), computed by square-and-multiply over m clock cycles.
module gf_sbox_engine #(
  parameter int unsigned    WIDTH = 8,
  parameter logic [WIDTH:0] POLY  = 9'h11B
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int unsigned     CntW     = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] One     = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic [WIDTH-1:0] r_sq;
  logic [WIDTH-1:0] cap_operand;
  logic [WIDTH-1:0] fin_result;

  // Carry-less product followed by full reduction modulo POLY.
  function automatic logic [WIDTH-1:0] gf_mul(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
    logic [2*WIDTH-2:0] p;
    p = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (y[i]) p = p ^ ({{(WIDTH-1){1'b0}}, x} << i);
    end
    for (int i = int'(2*WIDTH-2); i >= int'(WIDTH); i--) begin
      if (p[i]) p = p ^ ({{(WIDTH-2){1'b0}}, POLY} << (i - int'(WIDTH)));
    end
    return p[WIDTH-1:0];
  endfunction

  // AES affine: x ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
  function automatic logic [7:0] fwd_affine(input logic [7:0] x);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  // Inverse AES affine: rotl1 ^ rotl3 ^ rotl6 ^ 0x05.
  function automatic logic [7:0] inv_affine(input logic [7:0] x);
    return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
  endfunction

  // Affine stages exist only for the AES field; other widths always do a raw inverse.
  if (WIDTH == 8) begin : g_affine
    assign cap_operand = (in_mode == 2'b10) ? inv_affine(in_data) : in_data;
    assign fin_result  = (mode_q == 2'b01) ? fwd_affine(r_sq) : r_sq;
  end else begin : g_raw
    assign cap_operand = in_data;
    assign fin_result  = r_sq;
  end

  assign r_sq      = gf_mul(r_q, r_q);
  // Gated by rst_n so no operand is taken while reset is held.
  assign in_ready  = rst_n && ((state_q == StIdle) || ((state_q == StDone) && out_ready));
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q == StCalc);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Next-state logic: capture, square-and-multiply steps, result hand-off.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    r_d         = r_q;
    a_d         = a_q;
    mode_d      = mode_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          a_d     = cap_operand;
          mode_d  = in_mode;
          r_d     = One;
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (cnt_q == LastStep) begin
          out_data_d  = fin_result;
          out_valid_d = 1'b1;
          state_d     = StDone;
        end else begin
          r_d   = gf_mul(r_sq, a_q);
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
          if (accept) begin
            a_d     = cap_operand;
            mode_d  = in_mode;
            r_d     = One;
            cnt_d   = '0;
            state_d = StCalc;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      r_q         <= One;
      a_q         <= '0;
      mode_q      <= 2'b00;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      r_q         <= r_d;
      a_q         <= a_d;
      mode_q      <= mode_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
